// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with saturating
// direction counters, mispredict flush/redirect and statistics counters.
module btb_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is16,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  input  logic        stat_clear,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_W    = 31 - IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic                valid_q [ENTRIES];
  logic                valid_d [ENTRIES];
  logic [TAG_W-1:0]    tag_q   [ENTRIES];
  logic [TAG_W-1:0]    tag_d   [ENTRIES];
  logic [31:0]         tgt_q   [ENTRIES];
  logic [31:0]         tgt_d   [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q   [ENTRIES];
  logic [CNT_BITS-1:0] cnt_d   [ENTRIES];

  logic [31:0] br_q, br_d;
  logic [31:0] mp_q, mp_d;

  logic [IDX_BITS-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]    l_tag, u_tag;
  logic                l_hit, u_hit;
  logic                mispredict;
  logic                do_upd;
  logic                unused_pc_lsb;

  assign unused_pc_lsb = ^{lookup_pc[0], upd_pc[0]};

  assign l_idx = lookup_pc[IDX_BITS:1];
  assign l_tag = lookup_pc[31:IDX_BITS+1];
  assign u_idx = upd_pc[IDX_BITS:1];
  assign u_tag = upd_pc[31:IDX_BITS+1];

  // Combinational lookup against the pre-update table state
  always_comb begin
    l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = l_hit && cnt_q[l_idx][CNT_BITS-1];
    pred_target = pred_taken ? tgt_q[l_idx] : 32'd0;
  end

  // Mispredict detection and fetch redirect
  always_comb begin
    mispredict  = upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_pred_target != upd_target)));
    flush       = mispredict && !stall;
    redirect_pc = upd_taken ? upd_target
                            : upd_pc + (upd_is16 ? 32'd2 : 32'd4);
  end

  // Table training: counter update on hit, allocate on taken miss
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    do_upd  = upd_valid && !stall;
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    if (do_upd) begin
      if (u_hit) begin
        if (upd_taken) begin
          tgt_d[u_idx] = upd_target;
          if (cnt_q[u_idx] != CNT_MAX)
            cnt_d[u_idx] = cnt_q[u_idx] + CNT_ONE;
        end else if (cnt_q[u_idx] != CNT_ZERO) begin
          cnt_d[u_idx] = cnt_q[u_idx] - CNT_ONE;
        end
      end else if (upd_taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = upd_target;
        cnt_d[u_idx]   = CNT_WEAK;
      end
    end
  end

  // Statistics: clear wins over increment and ignores stall
  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (stat_clear) begin
      br_d = 32'd0;
      mp_d = 32'd0;
    end else if (!stall) begin
      if (upd_valid && (br_q != STAT_MAX))
        br_d = br_q + 32'd1;
      if (mispredict && (mp_q != STAT_MAX))
        mp_d = mp_q + 32'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      br_q <= 32'd0;
      mp_q <= 32'd0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed scenario tasks with inline checks
// for btb_predictor (ENTRIES=16, CNT_BITS=2).
module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is16;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        stat_clear;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  btb_predictor #(.ENTRIES(16), .CNT_BITS(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is16         (upd_is16),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .stat_clear       (stat_clear),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic drive_upd(input logic v, input logic [31:0] pc,
                           input logic is16, input logic tk,
                           input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_is16        = is16;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  task automatic idle_upd();
    drive_upd(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    stat_clear = 1'b0;
    lookup_pc = 32'h100;
    idle_upd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred_taken: got %0b expected 0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'd0) begin
      errors++;
      $display("FAIL reset_pred_target: got %h expected 0", pred_target);
    end
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got %0b expected 0", flush);
    end
    checks++;
    if (stat_branches !== 32'd0) begin
      errors++;
      $display("FAIL reset_stat_br: got %0d expected 0", stat_branches);
    end
    checks++;
    if (stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL reset_stat_mp: got %0d expected 0", stat_mispredicts);
    end
  endtask

  task automatic test_allocate();
    @(negedge clk);
    drive_upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
    lookup_pc = 32'h100;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL alloc_flush: got %0b expected 1", flush);
    end
    checks++;
    if (redirect_pc !== 32'h200) begin
      errors++;
      $display("FAIL alloc_redirect: got %h expected 200", redirect_pc);
    end
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL alloc_same_cycle: got %0b expected 0", pred_taken);
    end
    @(negedge clk);
    idle_upd();
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL alloc_pred_taken: got %0b expected 1", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h200) begin
      errors++;
      $display("FAIL alloc_pred_target: got %h expected 200", pred_target);
    end
    checks++;
    if (stat_branches !== 32'd1) begin
      errors++;
      $display("FAIL alloc_stat_br: got %0d expected 1", stat_branches);
    end
    checks++;
    if (stat_mispredicts !== 32'd1) begin
      errors++;
      $display("FAIL alloc_stat_mp: got %0d expected 1", stat_mispredicts);
    end
  endtask

  task automatic test_not_taken();
    @(negedge clk);
    drive_upd(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 1'b1, 32'h200);
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL nt_flush: got %0b expected 1", flush);
    end
    checks++;
    if (redirect_pc !== 32'h104) begin
      errors++;
      $display("FAIL nt_redirect32: got %h expected 104", redirect_pc);
    end
    upd_is16 = 1'b1;
    #1;
    checks++;
    if (redirect_pc !== 32'h102) begin
      errors++;
      $display("FAIL nt_redirect16: got %h expected 102", redirect_pc);
    end
    @(negedge clk);
    idle_upd();
    lookup_pc = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL nt_pred_taken: got %0b expected 0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'd0) begin
      errors++;
      $display("FAIL nt_pred_target: got %h expected 0", pred_target);
    end
    checks++;
    if (stat_branches !== 32'd2 || stat_mispredicts !== 32'd2) begin
      errors++;
      $display("FAIL nt_stats: got %0d/%0d expected 2/2",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_alias();
    @(negedge clk);
    drive_upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
    @(negedge clk);
    idle_upd();
    lookup_pc = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL alias_retrain: got %0b expected 1", pred_taken);
    end
    lookup_pc = 32'h120;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL alias_tag_miss: got %0b expected 0", pred_taken);
    end
    @(negedge clk);
    drive_upd(1'b1, 32'h120, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
    @(negedge clk);
    idle_upd();
    lookup_pc = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL alias_evicted: got %0b expected 0", pred_taken);
    end
    lookup_pc = 32'h120;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      errors++;
      $display("FAIL alias_new: got %0b/%h expected 1/300",
               pred_taken, pred_target);
    end
    checks++;
    if (stat_branches !== 32'd4 || stat_mispredicts !== 32'd4) begin
      errors++;
      $display("FAIL alias_stats: got %0d/%0d expected 4/4",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall = 1'b1;
    drive_upd(1'b1, 32'h104, 1'b0, 1'b1, 32'h400, 1'b0, 32'd0);
    lookup_pc = 32'h104;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (flush !== 1'b0) begin
        errors++;
        $display("FAIL stall_flush_c%0d: got %0b expected 0", i, flush);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL stall_table: got %0b expected 0", pred_taken);
    end
    checks++;
    if (stat_branches !== 32'd4 || stat_mispredicts !== 32'd4) begin
      errors++;
      $display("FAIL stall_stats: got %0d/%0d expected 4/4",
               stat_branches, stat_mispredicts);
    end
    stall = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_flush: got %0b expected 1", flush);
    end
    @(negedge clk);
    idle_upd();
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
      errors++;
      $display("FAIL stall_release_pred: got %0b/%h expected 1/400",
               pred_taken, pred_target);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd5) begin
      errors++;
      $display("FAIL stall_once: got %0d/%0d expected 5/5",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_wrong_target();
    @(negedge clk);
    drive_upd(1'b1, 32'h104, 1'b0, 1'b1, 32'h440, 1'b1, 32'h400);
    lookup_pc = 32'h104;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h440) begin
      errors++;
      $display("FAIL wt_flush: got %0b/%h expected 1/440",
               flush, redirect_pc);
    end
    @(negedge clk);
    drive_upd(1'b1, 32'h104, 1'b0, 1'b1, 32'h440, 1'b1, 32'h440);
    #1;
    checks++;
    if (pred_target !== 32'h440) begin
      errors++;
      $display("FAIL wt_target_upd: got %h expected 440", pred_target);
    end
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL wt_correct_flush: got %0b expected 0", flush);
    end
    @(negedge clk);
    drive_upd(1'b1, 32'h104, 1'b0, 1'b0, 32'd0, 1'b1, 32'h440);
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h108) begin
      errors++;
      $display("FAIL wt_nt_flush: got %0b/%h expected 1/108",
               flush, redirect_pc);
    end
    @(negedge clk);
    idle_upd();
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h440) begin
      errors++;
      $display("FAIL wt_saturate: got %0b/%h expected 1/440",
               pred_taken, pred_target);
    end
    checks++;
    if (stat_branches !== 32'd8 || stat_mispredicts !== 32'd7) begin
      errors++;
      $display("FAIL wt_stats: got %0d/%0d expected 8/7",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_upd(1'b1, 32'h108, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    checks++;
    if (flush !== 1'b0 || redirect_pc !== 32'h10C) begin
      errors++;
      $display("FAIL b2b_nt_ok: got %0b/%h expected 0/10c",
               flush, redirect_pc);
    end
    @(negedge clk);
    drive_upd(1'b1, 32'h10A, 1'b1, 1'b1, 32'h600, 1'b0, 32'd0);
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h600) begin
      errors++;
      $display("FAIL b2b_c_flush: got %0b/%h expected 1/600",
               flush, redirect_pc);
    end
    @(negedge clk);
    idle_upd();
    lookup_pc = 32'h108;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_alloc: got %0b expected 0", pred_taken);
    end
    lookup_pc = 32'h10A;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h600) begin
      errors++;
      $display("FAIL b2b_half_entry: got %0b/%h expected 1/600",
               pred_taken, pred_target);
    end
    checks++;
    if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd8) begin
      errors++;
      $display("FAIL b2b_stats: got %0d/%0d expected 10/8",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_stat_clear();
    @(negedge clk);
    stall = 1'b1;
    stat_clear = 1'b1;
    drive_upd(1'b1, 32'h140, 1'b0, 1'b1, 32'h700, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL clr_stall: got %0d/%0d expected 0/0",
               stat_branches, stat_mispredicts);
    end
    stall = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL clr_priority: got %0d/%0d expected 0/0",
               stat_branches, stat_mispredicts);
    end
    stat_clear = 1'b0;
    drive_upd(1'b1, 32'h140, 1'b0, 1'b1, 32'h700, 1'b1, 32'h700);
    @(negedge clk);
    idle_upd();
    #1;
    checks++;
    if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL clr_resume: got %0d/%0d expected 1/0",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_upd(1'b1, 32'h108, 1'b0, 1'b1, 32'h500, 1'b0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_upd();
    lookup_pc = 32'h104;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL rmid_104: got %0b expected 0", pred_taken);
    end
    lookup_pc = 32'h10A;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL rmid_10a: got %0b expected 0", pred_taken);
    end
    lookup_pc = 32'h108;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL rmid_pending: got %0b expected 0", pred_taken);
    end
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL rmid_stats: got %0d/%0d expected 0/0",
               stat_branches, stat_mispredicts);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_not_taken();
    test_alias();
    test_stall();
    test_wrong_target();
    test_back_to_back();
    test_stat_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
